// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: field inputs, output word stream,
// soft restart and illegal-request reporting.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 8
);
  logic              restart;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ImmSrc;
  logic [31:0]       imm;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output restart, in_valid, ImmSrc, imm, opcode, rd, rs1, rs2, funct3, funct7, out_ready,
    input  in_ready, out_valid, out_word, out_addr, err_pulse, err_count
  );

  modport slave (
    input  restart, in_valid, ImmSrc, imm, opcode, rd, rs1, rs2, funct3, funct7, out_ready,
    output in_ready, out_valid, out_word, out_addr, err_pulse, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields plus a full immediate into an instruction word, rejects
// immediates the selected format cannot represent, and streams words with addresses.
module instr_encoder #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        ERR_W     = 8
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_U     = 3'b001,
    SRC_S     = 3'b010,
    SRC_B     = 3'b011,
    SRC_J     = 3'b100,
    SRC_SHAMT = 3'b101,
    SRC_RSVD  = 3'b110,
    SRC_R     = 3'b111
  } imm_src_e;

  // An immediate is legal when sign-extending the format's field reproduces it.
  function automatic logic imm_legal(input logic [2:0] src, input logic [31:0] imm);
    logic ok;
    case (imm_src_e'(src))
      SRC_I, SRC_S: ok = (imm[31:11] == {21{imm[11]}});
      SRC_B:        ok = (imm[31:13] == {19{imm[12]}}) && (imm[0] == 1'b0);
      SRC_J:        ok = (imm[31:21] == {11{imm[20]}}) && (imm[0] == 1'b0);
      SRC_U:        ok = (imm[11:0] == 12'h000);
      SRC_SHAMT:    ok = (imm[31:5] == 27'h0);
      SRC_R:        ok = 1'b1;
      SRC_RSVD:     ok = 1'b0;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  src,
    input logic [31:0] imm,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7
  );
    logic [31:0] w;
    case (imm_src_e'(src))
      SRC_I:     w = {imm[11:0], rs1, funct3, rd, opcode};
      SRC_U:     w = {imm[31:12], rd, opcode};
      SRC_S:     w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      SRC_B:     w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      SRC_J:     w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      SRC_SHAMT: w = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      SRC_R:     w = {funct7, rs2, rs1, funct3, rd, opcode};
      default:   w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q,  out_word_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              in_ready_s;
  logic              accept_s;
  logic              legal_s;
  logic [31:0]       enc_word_s;

  assign in_ready_s = !bus.restart && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign legal_s    = imm_legal(bus.ImmSrc, bus.imm);
  assign enc_word_s = encode(bus.ImmSrc, bus.imm, bus.opcode, bus.rd, bus.rs1,
                             bus.rs2, bus.funct3, bus.funct7);

  // Restart overrides both handshakes; otherwise drain first, then load the new word.
  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (bus.restart) begin
      out_valid_d = 1'b0;
      out_addr_d  = BASE_ADDR;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q + ADDR_W'(4);
      end else begin
        out_addr_d  = out_addr_q;
      end
      if (accept_s && legal_s) begin
        out_valid_d = 1'b1;
        out_word_d  = enc_word_s;
      end else if (accept_s) begin
        err_pulse_d = 1'b1;
        if (err_count_q != {ERR_W{1'b1}}) begin
          err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
          err_count_d = err_count_q;
        end
      end else begin
        err_pulse_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0000_0000;
      out_addr_q  <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule
